// File: rtl/covox_dac_pkg.sv
// Shared defaults and constants for the Covox / beeper sigma-delta DAC.
package covox_dac_pkg;

  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam int unsigned MIX_W_DEF    = 10;
  localparam int unsigned BEEP_LVL_DEF = 192;
  localparam int unsigned TAPE_LVL_DEF = 64;
  localparam int unsigned RATE_DIV_DEF = 80;

  // Saturation point of the default-width mixer.
  localparam int unsigned MIX_MAX = (1 << MIX_W_DEF) - 1;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_AW    = 2;

endpackage : covox_dac_pkg

// File: rtl/covox_beeper_dac_sd_mod1.sv
// First-order sigma-delta modulator: the accumulator carry is the output bit.
module sd_mod1
  import covox_dac_pkg::*;
#(
  parameter int unsigned MIX_W = MIX_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [MIX_W-1:0] mix_i,
  output logic             bit_o
);

  logic [MIX_W-1:0] acc_q;
  logic [MIX_W-1:0] acc_d;
  logic             carry_d;

  always_comb begin
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, mix_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      bit_o <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bit_o <= carry_d;
    end
  end

endmodule : sd_mod1

// File: rtl/covox_beeper_dac.sv
// Covox sample capture, beeper/tapeout mixing and 1-bit sigma-delta audio output.
// Build option: define COVOX_FIFO_EN for a 4-deep paced sample FIFO with sticky overflow flag.
module covox_beeper_dac
  import covox_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned MIX_W    = MIX_W_DEF,
  parameter int unsigned BEEP_LVL = BEEP_LVL_DEF,
  parameter int unsigned TAPE_LVL = TAPE_LVL_DEF,
  parameter int unsigned RATE_DIV = RATE_DIV_DEF
) (
  input  logic                cpu_clock,
  input  logic                reset,
  input  logic                covox_stb,
  input  logic [SAMPLE_W-1:0] d,
  input  logic                beeper,
  input  logic                tapeout,
  output logic                dac_out,
  output logic [SAMPLE_W-1:0] sample_q,
  output logic                fifo_ovf
);

  localparam int unsigned SUM_W = MIX_W + 2;
  localparam logic [SUM_W-1:0] MIX_SAT = SUM_W'((1 << MIX_W) - 1);

  logic                stb_q;
  logic                stb_prev_q;
  logic [SAMPLE_W-1:0] d_q;
  logic                bp_q;
  logic                tp_q;
  logic                commit_c;
  logic [SAMPLE_W-1:0] sample_d;
  logic [SUM_W-1:0]    mix_sum_c;
  logic [MIX_W-1:0]    mix_d;
  logic [MIX_W-1:0]    mix_q;

  // Input capture; reset reloads the strobe history from the live strobe so a
  // pulse that spans reset is treated as already seen and never commits.
  always_ff @(posedge cpu_clock) begin
    stb_q      <= covox_stb;
    d_q        <= d;
    bp_q       <= beeper;
    tp_q       <= tapeout;
    stb_prev_q <= reset ? covox_stb : stb_q;
  end

  assign commit_c = stb_q & ~stb_prev_q;

`ifdef COVOX_FIFO_EN
  localparam int unsigned PTR_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] PACE_TC = CNT_W'(RATE_DIV - 1);

  logic [SAMPLE_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_d;
  logic [CNT_W-1:0]    pace_q;
  logic [CNT_W-1:0]    pace_d;
  logic                ovf_d;
  logic                empty_c;
  logic                full_c;
  logic                pop_c;
  logic                push_c;

  // Pop is decided on pre-push occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
               (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
    pop_c    = (pace_q == PACE_TC) && !empty_c;
    push_c   = commit_c && (!full_c || pop_c);
    pace_d   = (pace_q == PACE_TC) ? '0 : pace_q + CNT_W'(1);
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    ovf_d    = fifo_ovf | (commit_c & full_c & ~pop_c);
    sample_d = pop_c ? fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]] : sample_q;
  end

  // Storage has no reset; the pointers define which entries are live.
  always_ff @(posedge cpu_clock) begin
    if (push_c) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= d_q;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pace_q   <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pace_q   <= pace_d;
      fifo_ovf <= ovf_d;
    end
  end
`else
  always_comb begin
    sample_d = sample_q;
    if (commit_c) begin
      sample_d = d_q;
    end
  end

  assign fifo_ovf = 1'b0;
`endif

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  // Mixer sums at two extra bits of headroom, then clips to full scale.
  always_comb begin
    mix_sum_c = SUM_W'(sample_q)
              + (bp_q ? SUM_W'(BEEP_LVL) : '0)
              + (tp_q ? SUM_W'(TAPE_LVL) : '0);
    mix_d     = (mix_sum_c > MIX_SAT) ? MIX_W'(MIX_SAT) : MIX_W'(mix_sum_c);
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  sd_mod1 #(
    .MIX_W (MIX_W)
  ) u_sd_mod1 (
    .clk_i (cpu_clock),
    .rst_i (reset),
    .mix_i (mix_q),
    .bit_o (dac_out)
  );

endmodule : covox_beeper_dac

// File: tb/tb_covox_beeper_dac.sv
// Bench for covox_beeper_dac: cycle model of the audio path plus directed literal checks.
// Define COVOX_FIFO_EN to exercise the paced FIFO build.
module tb_covox_beeper_dac;

`ifdef COVOX_FIFO_EN
  localparam int RD = 10;
`else
  localparam int RD = 80;
`endif
  localparam int FULL = 1024;
  localparam int MAXV = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       covox_stb;
  logic [7:0] d;
  logic       beeper;
  logic       tapeout;
  logic       dac_out, dac_sat;
  logic [7:0] sample_q, sample_sat;
  logic       fifo_ovf, ovf_sat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  covox_beeper_dac #(.RATE_DIV(RD)) u_dut (
    .cpu_clock (clk),
    .reset     (reset),
    .covox_stb (covox_stb),
    .d         (d),
    .beeper    (beeper),
    .tapeout   (tapeout),
    .dac_out   (dac_out),
    .sample_q  (sample_q),
    .fifo_ovf  (fifo_ovf)
  );

  // Same stimulus with oversized levels to force mixer saturation.
  covox_beeper_dac #(.BEEP_LVL(1000), .TAPE_LVL(1000), .RATE_DIV(RD)) u_sat (
    .cpu_clock (clk),
    .reset     (reset),
    .covox_stb (covox_stb),
    .d         (d),
    .beeper    (beeper),
    .tapeout   (tapeout),
    .dac_out   (dac_sat),
    .sample_q  (sample_sat),
    .fifo_ovf  (ovf_sat)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: played sample, per-instance mix level and phase accumulator.
  int  m_sample = 0;
  int  m_mix[2]   = '{0, 0};
  int  m_phase[2] = '{0, 0};
  bit  m_dac[2]   = '{0, 0};
  bit  m_ovf = 0;
  int  m_since = 0;
  int  q[$];
  int  lvl_b[2] = '{192, 1000};
  int  lvl_t[2] = '{64, 1000};
  bit  h_stb1 = 0, h_stb2 = 0, h_rst1 = 1, h_bp1 = 0, h_tp1 = 0;
  int  h_d1 = 0;
  bit  started = 0;

  always @(posedge clk) begin : p_model
    bit commit;
    bit pop;
    int tot;
    commit = !h_rst1 && h_stb1 && !h_stb2;
    if (reset) begin
      m_sample = 0;
      m_mix    = '{0, 0};
      m_phase  = '{0, 0};
      m_dac    = '{0, 0};
      m_ovf    = 0;
      m_since  = 0;
      q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        tot        = m_phase[i] + m_mix[i];
        m_dac[i]   = (tot >= FULL);
        m_phase[i] = tot % FULL;
        tot        = m_sample + (h_bp1 ? lvl_b[i] : 0) + (h_tp1 ? lvl_t[i] : 0);
        m_mix[i]   = (tot > MAXV) ? MAXV : tot;
      end
`ifdef COVOX_FIFO_EN
      pop = ((m_since % RD) == RD - 1);
      m_since++;
      if (pop && q.size() > 0) m_sample = q.pop_front();
      if (commit) begin
        if (q.size() < 4) q.push_back(h_d1);
        else m_ovf = 1;
      end
`else
      pop = 0;
      if (commit) m_sample = h_d1;
`endif
    end
    h_stb2  = h_stb1;
    h_stb1  = covox_stb;
    h_d1    = int'(d);
    h_bp1   = beeper;
    h_tp1   = tapeout;
    h_rst1  = reset;
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sample_q", int'(sample_q), m_sample);
      chk("dac_out", int'(dac_out), int'(m_dac[0]));
      chk("fifo_ovf", int'(fifo_ovf), int'(m_ovf));
      chk("sat_sample_q", int'(sample_sat), m_sample);
      chk("sat_dac_out", int'(dac_sat), int'(m_dac[1]));
      chk("sat_fifo_ovf", int'(ovf_sat), int'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_ones(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(dac_out);
      c1 += int'(dac_sat);
    end
  endtask

`ifdef COVOX_FIFO_EN
  task automatic wait_pre(input int p);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if ((m_since % RD) == p) hit = 1;
      else tick(1);
    end
    chk("pace_align", int'(hit), 1);
  endtask
`endif

  initial begin : p_stim
    int c0, c1;
    reset = 1'b1; covox_stb = 1'b1; d = 8'hFF; beeper = 1'b0; tapeout = 1'b0;
    tick(3);
    chk("rst_sample", int'(sample_q), 0);
    chk("rst_dac", int'(dac_out), 0);
    reset = 1'b0;
    tick(4);
    chk("held_stb_no_commit", int'(sample_q), 0);
    covox_stb = 1'b0;
    tick(2);
    chk("stb_fall_no_commit", int'(sample_q), 0);
    count_ones(FULL, c0, c1);
    chk("ones_mix0", c0, 0);
    chk("ones_mix0_sat", c1, 0);

`ifndef COVOX_FIFO_EN
    // Single write, strobe held 3 cycles
    d = 8'h80; covox_stb = 1'b1;
    tick(1);
    chk("write_not_yet", int'(sample_q), 0);
    tick(1);
    chk("write_lat2", int'(sample_q), 8'h80);
    tick(1);
    covox_stb = 1'b0; d = 8'h11;
    tick(5);
    count_ones(FULL, c0, c1);
    chk("ones_128", c0, 128);
    chk("ones_128_sat", c1, 128);

    // Full-scale sample with beeper and tapeout
    d = 8'hFF; covox_stb = 1'b1; beeper = 1'b1; tapeout = 1'b1;
    tick(1);
    covox_stb = 1'b0;
    tick(6);
    count_ones(FULL, c0, c1);
    chk("ones_511", c0, 511);
    chk("ones_sat_1023", c1, 1023);

    // Three short pulses, one commit each
    beeper = 1'b0; tapeout = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      d = 8'(v); covox_stb = 1'b1;
      tick(2);
      covox_stb = 1'b0;
      tick(1);
    end
    tick(3);
    chk("three_pulses", int'(sample_q), 3);

    // Reset mid-operation
    beeper = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(1);
    chk("midrst_sample", int'(sample_q), 0);
    chk("midrst_dac", int'(dac_out), 0);
    reset = 1'b0;
    tick(5);
`else
    // Five pushes between two pops: the fifth is dropped
    wait_pre(9);
    for (int i = 0; i < 10; i++) begin
      covox_stb = (i % 2 == 0);
      d = 8'(i / 2 + 1);
      tick(1);
    end
    covox_stb = 1'b0;
    chk("ovf_set", int'(fifo_ovf), 1);
    chk("ovf_no_pop_yet", int'(sample_q), 0);
    tick(1);
    chk("pop_1", int'(sample_q), 1);
    for (int k = 2; k <= 4; k++) begin
      tick(RD);
      chk("pop_k", int'(sample_q), k);
    end
    tick(RD);
    chk("pop_hold_4", int'(sample_q), 4);
    chk("ovf_sticky", int'(fifo_ovf), 1);

    // Full FIFO, push aligned with a pop
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("ovf_cleared", int'(fifo_ovf), 0);
    wait_pre(9);
    begin
      int stb_pat[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
      int d_pat[10]   = '{1, 0, 2, 0, 3, 0, 4, 0, 0, 5};
      for (int i = 0; i < 10; i++) begin
        covox_stb = stb_pat[i][0];
        d = 8'(d_pat[i]);
        tick(1);
      end
    end
    covox_stb = 1'b0;
    tick(1);
    chk("aligned_no_ovf", int'(fifo_ovf), 0);
    chk("aligned_pop_1", int'(sample_q), 1);
    tick(4 * RD);
    chk("aligned_push_plays", int'(sample_q), 5);
    chk("aligned_no_ovf_end", int'(fifo_ovf), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_covox_beeper_dac
